memstream_config_loader: RTL and testbench
==========================================

Name: memstream_config_loader

Overview:
Sequencer that loads weight/parameter memory of the multi-stream memstream block through its ap_memory-style config write port. It accepts an AXI-Stream of 32-bit words and writes them to consecutive addresses from BASE_ADDR. During a load it holds all memstream readers via a hold output, which is ORed into every stream's afull. It checks word count against tlast and reports done and error status.

Parameters:
LOAD_DEPTH, 13824, number of words one load must deliver (>=1)
BASE_ADDR, 0, first config address written
DRAIN_CYCLES, 4, cycles to wait after asserting hold before the first write; covers the memstream read pipeline (>=1)

Ports:
aclk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle load request; honoured only in IDLE
s_axis_tdata  in  32  weight word
s_axis_tvalid  in  1  AXI-Stream valid
s_axis_tready  out  1  AXI-Stream ready
s_axis_tlast  in  1  marks the final word of the load
config_address  out  32  memstream config address
config_ce  out  1  config chip enable
config_we  out  1  config write enable
config_d0  out  32  config write data
hold  out  1  stall all memstream readers; ORed into each m_axis_N_afull
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a load finishes, with or without error
err_code  out  2  sticky status: 0 = ok, 1 = underrun (early tlast), 2 = overrun (no tlast at LOAD_DEPTH); cleared by an accepted start
words_loaded  out  $clog2(LOAD_DEPTH+1)  words written by the current or last load

Behaviour:
- Reset values: every output is 0; state is IDLE; internal counters are 0. Reset wins over all other events.
- Handshake: a beat is accepted when s_axis_tvalid & s_axis_tready. s_axis_tready is a registered-state decode and is high only in LOAD and FLUSH.
- FSM states: IDLE, DRAIN, LOAD, FLUSH, DONE.
- IDLE:
  - hold=0, busy=0.
  - start -> DRAIN. On entry: hold=1, err_code=0, words_loaded=0, drain counter=DRAIN_CYCLES-1.
- DRAIN:
  - hold=1. The counter decrements each cycle.
  - At 0 -> LOAD.
  - The first beat can be accepted no earlier than DRAIN_CYCLES cycles after start is sampled.
- LOAD, on an accepted beat with n = words_loaded before the beat:
  - Next cycle: config_ce=config_we=1, config_address=BASE_ADDR+n (32-bit, wraps modulo 2^32), config_d0=tdata. Write latency is exactly 1 cycle; the strobe is 0 in every cycle without a preceding beat.
  - words_loaded <= n+1.
  - tlast and n+1==LOAD_DEPTH -> DONE, err_code=0.
  - tlast and n+1<LOAD_DEPTH -> DONE, err_code=1.
  - no tlast and n+1==LOAD_DEPTH -> FLUSH, err_code=2.
  - Gaps in tvalid are tolerated indefinitely. There is no timeout.
- FLUSH:
  - tready=1. Beats are discarded with no write strobe.
  - A beat with tlast -> DONE. err_code stays 2.
- DONE:
  - done=1 for exactly this cycle. hold=1 so the last write (issued this cycle) lands while readers are stalled.
  - -> IDLE next cycle. hold drops then.
- start outside IDLE is ignored, including start in the same cycle DONE returns to IDLE.
- Reset during DRAIN/LOAD/FLUSH: next cycle hold=0 and config_we=0. No further writes. The partial load is not reported (done stays 0).
- config_ce and config_we are always equal. Reads through the config port are not supported.

Decomposition:
- Shared package memstream_cfg_pkg:
  - state enum
  - err_code constants ERR_OK, ERR_UNDERRUN, ERR_OVERRUN
  - config data/address width constant CFG_W=32
- Single module. No sub-module is warranted; the counters and FSM are one process group.

Test Plan:
Bench uses LOAD_DEPTH=8, BASE_ADDR=16, DRAIN_CYCLES=4.
- Nominal: start, then 8 beats 0xA0..0xA7 back-to-back, tlast on the 8th -> first tready no earlier than 4 cycles after start; writes to addresses 16..23 with data 0xA0..0xA7, each 1 cycle after its beat; done pulses once; err_code=0; words_loaded=8; hold high from start+1 through the DONE cycle.
- Throttled source: same 8 beats with random tvalid gaps of 0-5 cycles -> identical write sequence; no write strobe in any gap cycle.
- Underrun: tlast on beat 5 -> 5 writes (addresses 16..20); done pulses; err_code=1; words_loaded=5.
- Overrun: 11 beats, tlast on the 11th -> 8 writes only; beats 9-11 accepted with no strobe; done after beat 11; err_code=2.
- Reset mid-load: rst asserted after beat 3 -> next cycle hold=0, busy=0, config_we=0; no done pulse; a fresh start then runs the nominal case cleanly with err_code cleared.
- Ignored start: pulse start during LOAD and again in the DONE cycle -> no restart, err_code unchanged; one done pulse total.

Source files
------------

// File: rtl/memstream_cfg_pkg.sv
// Shared types and constants for the memstream config loader.
package memstream_cfg_pkg;

    localparam int CFG_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_UNDERRUN = 2'd1;
    localparam logic [1:0] ERR_OVERRUN  = 2'd2;

endpackage

// File: rtl/memstream_config_loader.sv
// Streams an AXI-Stream of weight words into the memstream config port,
// holding all memstream readers for the duration of the load.
module memstream_config_loader
    import memstream_cfg_pkg::*;
#(
    parameter int unsigned      LOAD_DEPTH   = 13824,
    parameter logic [CFG_W-1:0] BASE_ADDR    = '0,
    parameter int unsigned      DRAIN_CYCLES = 4
) (
    input  logic                              aclk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CFG_W-1:0]                  s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [CFG_W-1:0]                  config_address,
    output logic                              config_ce,
    output logic                              config_we,
    output logic [CFG_W-1:0]                  config_d0,
    output logic                              hold,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        err_code,
    output logic [$clog2(LOAD_DEPTH+1)-1:0]   words_loaded
);

    localparam int CNT_W   = $clog2(LOAD_DEPTH + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             state;
    state_t             state_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;
    logic [CNT_W-1:0]   words_next;
    logic               at_depth;

    assign accept     = s_axis_tvalid && s_axis_tready;
    assign words_next = words_loaded + CNT_W'(1);
    assign at_depth   = (words_next == CNT_W'(LOAD_DEPTH));

    // Status strobes decode the registered state, so they are glitch-free and reset to 0.
    assign s_axis_tready = (state == ST_LOAD) || (state == ST_FLUSH);
    assign busy          = (state != ST_IDLE);
    assign hold          = busy;
    assign done          = (state == ST_DONE);
    assign config_ce     = config_we;

    always_ff @(posedge aclk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next takes its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == '0) state_next = ST_LOAD;
            ST_LOAD: begin
                if (accept) begin
                    if (s_axis_tlast)  state_next = ST_DONE;
                    else if (at_depth) state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: if (accept && s_axis_tlast) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (rst) begin
            drain_cnt      <= '0;
            words_loaded   <= '0;
            err_code       <= ERR_OK;
            config_we      <= 1'b0;
            config_address <= '0;
            config_d0      <= '0;
        end else begin
            config_we <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_code     <= ERR_OK;
                        words_loaded <= '0;
                        drain_cnt    <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - DRAIN_W'(1);
                end
                ST_LOAD: begin
                    if (accept) begin
                        config_we      <= 1'b1;
                        config_address <= BASE_ADDR + CFG_W'(words_loaded);
                        config_d0      <= s_axis_tdata;
                        words_loaded   <= words_next;
                        if (s_axis_tlast) begin
                            err_code <= at_depth ? ERR_OK : ERR_UNDERRUN;
                        end else if (at_depth) begin
                            err_code <= ERR_OVERRUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memstream_config_loader.sv
// Directed self-checking bench for memstream_config_loader (LOAD_DEPTH=8, BASE_ADDR=16, DRAIN_CYCLES=4).
module tb_memstream_config_loader;

    localparam int          LOAD_DEPTH   = 8;
    localparam logic [31:0] BASE_ADDR    = 32'd16;
    localparam int          DRAIN_CYCLES = 4;
    localparam int          CNT_W        = $clog2(LOAD_DEPTH + 1);

    logic             aclk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      s_axis_tdata = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic             s_axis_tlast = 1'b0;
    logic [31:0]      config_address;
    logic             config_ce;
    logic             config_we;
    logic [31:0]      config_d0;
    logic             hold;
    logic             busy;
    logic             done;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] words_loaded;

    memstream_config_loader #(
        .LOAD_DEPTH  (LOAD_DEPTH),
        .BASE_ADDR   (BASE_ADDR),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .aclk          (aclk),
        .rst           (rst),
        .start         (start),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .config_address(config_address),
        .config_ce     (config_ce),
        .config_we     (config_we),
        .config_d0     (config_d0),
        .hold          (hold),
        .busy          (busy),
        .done          (done),
        .err_code      (err_code),
        .words_loaded  (words_loaded)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {int cyc; logic [31:0] data; logic last;} acc_t;
    typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} wr_t;

    acc_t acc_q[$];
    wr_t  wr_q[$];
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   hold_rise_cyc = -1;
    int   hold_fall_cyc = -1;
    int   ce_mismatch = 0;
    logic prev_hold = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    // Passive log of handshakes, writes, done pulses and hold edges, sampled mid-cycle.
    always @(negedge aclk) begin
        if (s_axis_tvalid && s_axis_tready) acc_q.push_back('{cyc, s_axis_tdata, s_axis_tlast});
        if (config_we) wr_q.push_back('{cyc, config_address, config_d0});
        if (config_ce !== config_we) ce_mismatch++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hold && !prev_hold) hold_rise_cyc = cyc;
        if (!hold && prev_hold) hold_fall_cyc = cyc;
        prev_hold = hold;
    end

    task automatic do_start(output int s_cyc);
        @(posedge aclk); #1;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic send_beats(input int n, input int last_idx, input int max_gap, input logic [31:0] base);
        bit got;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin @(posedge aclk); #1; end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + 32'(i);
            s_axis_tlast  = (i == last_idx);
            got = 1'b0;
            for (int w = 0; w < 100 && !got; w++) begin
                @(negedge aclk);
                if (s_axis_tready === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL beat_accept_timeout beat=%0d tready=%b expected 1 within 100 cycles", i, s_axis_tready);
            end
            @(posedge aclk); #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int w = 0; w < budget && !got; w++) begin
            @(negedge aclk);
            if (done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout done=%b expected pulse within %0d cycles", done, budget);
        end
        @(negedge aclk);
        @(posedge aclk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({hold, busy, done, config_we, config_ce, s_axis_tready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got hold/busy/done/we/ce/tready=%b expected 000000",
                     {hold, busy, done, config_we, config_ce, s_axis_tready});
        end
        checks++;
        if (err_code !== 2'd0 || words_loaded !== '0 || config_address !== '0 || config_d0 !== '0) begin
            failures++;
            $display("FAIL reset_values got err=%0d words=%0d addr=%0h d0=%0h expected all 0",
                     err_code, words_loaded, config_address, config_d0);
        end
        @(posedge aclk); #1;
        rst = 1'b0;
    endtask

    task automatic test_nominal(input int max_gap, input string tag);
        int a0, w0, d0, s;
        a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        do_start(s);
        send_beats(8, 7, max_gap, 32'hA0);
        wait_done(50);
        checks++;
        if (acc_q.size() - a0 != 8 || wr_q.size() - w0 != 8) begin
            failures++;
            $display("FAIL %s_counts got accepts=%0d writes=%0d expected 8/8", tag, acc_q.size() - a0, wr_q.size() - w0);
        end else begin
            checks++;
            if (acc_q[a0].cyc - s < DRAIN_CYCLES) begin
                failures++;
                $display("FAIL %s_drain got first accept %0d cycles after start expected >= %0d",
                         tag, acc_q[a0].cyc - s, DRAIN_CYCLES);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_q[w0+i].addr !== BASE_ADDR + 32'(i) || wr_q[w0+i].data !== 32'hA0 + 32'(i)
                    || wr_q[w0+i].cyc != acc_q[a0+i].cyc + 1) begin
                    failures++;
                    $display("FAIL %s_write%0d got addr=%0d data=%0h lat=%0d expected addr=%0d data=%0h lat=1",
                             tag, i, wr_q[w0+i].addr, wr_q[w0+i].data, wr_q[w0+i].cyc - acc_q[a0+i].cyc,
                             BASE_ADDR + 32'(i), 32'hA0 + 32'(i));
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || err_code !== 2'd0 || words_loaded !== CNT_W'(8)) begin
            failures++;
            $display("FAIL %s_status got done_pulses=%0d err=%0d words=%0d expected 1/0/8",
                     tag, done_cnt - d0, err_code, words_loaded);
        end
        checks++;
        if (hold_rise_cyc != s + 1 || hold_fall_cyc != done_cyc + 1) begin
            failures++;
            $display("FAIL %s_hold_window got rise=%0d fall=%0d expected rise=%0d fall=%0d",
                     tag, hold_rise_cyc, hold_fall_cyc, s + 1, done_cyc + 1);
        end
    endtask

    task automatic test_underrun();
        int a0, w0, d0, s;
        a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        do_start(s);
        send_beats(5, 4, 0, 32'h50);
        wait_done(50);
        checks++;
        if (wr_q.size() - w0 != 5) begin
            failures++;
            $display("FAIL underrun_writes got %0d expected 5", wr_q.size() - w0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_q[w0+i].addr !== BASE_ADDR + 32'(i) || wr_q[w0+i].data !== 32'h50 + 32'(i)) begin
                    failures++;
                    $display("FAIL underrun_write%0d got addr=%0d data=%0h expected addr=%0d data=%0h",
                             i, wr_q[w0+i].addr, wr_q[w0+i].data, BASE_ADDR + 32'(i), 32'h50 + 32'(i));
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || err_code !== 2'd1 || words_loaded !== CNT_W'(5)) begin
            failures++;
            $display("FAIL underrun_status got done_pulses=%0d err=%0d words=%0d expected 1/1/5",
                     done_cnt - d0, err_code, words_loaded);
        end
    endtask

    task automatic test_overrun();
        int a0, w0, d0, s;
        a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        do_start(s);
        send_beats(11, 10, 0, 32'h70);
        wait_done(50);
        checks++;
        if (acc_q.size() - a0 != 11 || wr_q.size() - w0 != 8) begin
            failures++;
            $display("FAIL overrun_counts got accepts=%0d writes=%0d expected 11/8", acc_q.size() - a0, wr_q.size() - w0);
        end else begin
            checks++;
            if (wr_q[w0+7].addr !== BASE_ADDR + 32'd7 || wr_q[w0+7].data !== 32'h77) begin
                failures++;
                $display("FAIL overrun_last_write got addr=%0d data=%0h expected addr=23 data=77",
                         wr_q[w0+7].addr, wr_q[w0+7].data);
            end
            checks++;
            if (done_cyc != acc_q[a0+10].cyc + 1) begin
                failures++;
                $display("FAIL overrun_done_time got cycle=%0d expected %0d", done_cyc, acc_q[a0+10].cyc + 1);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || err_code !== 2'd2 || words_loaded !== CNT_W'(8)) begin
            failures++;
            $display("FAIL overrun_status got done_pulses=%0d err=%0d words=%0d expected 1/2/8",
                     done_cnt - d0, err_code, words_loaded);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0, d0, s;
        w0 = wr_q.size(); d0 = done_cnt;
        do_start(s);
        send_beats(3, -1, 0, 32'hB0);
        rst = 1'b1;
        @(posedge aclk); #1;
        rst = 1'b0;
        checks++;
        if ({hold, busy, config_we, s_axis_tready} !== 4'b0 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got hold/busy/we/tready=%b err=%0d expected 0000 err=0",
                     {hold, busy, config_we, s_axis_tready}, err_code);
        end
        repeat (10) @(posedge aclk);
        #1;
        checks++;
        if (done_cnt - d0 != 0 || wr_q.size() - w0 != 3) begin
            failures++;
            $display("FAIL reset_mid_aftermath got done_pulses=%0d writes=%0d expected 0/3",
                     done_cnt - d0, wr_q.size() - w0);
        end
        test_nominal(0, "after_reset");
    endtask

    task automatic test_ignored_start();
        int w0, d0, s;
        bit restarted = 1'b0;
        w0 = wr_q.size(); d0 = done_cnt;
        do_start(s);
        send_beats(4, -1, 0, 32'hC0);
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || err_code !== 2'd0 || words_loaded !== CNT_W'(4)) begin
            failures++;
            $display("FAIL ignored_start_load got busy=%b err=%0d words=%0d expected 1/0/4", busy, err_code, words_loaded);
        end
        send_beats(4, 3, 0, 32'hC4);
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (busy !== 1'b0) restarted = 1'b1;
        end
        checks++;
        if (restarted || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL ignored_start_done got restarted=%b done_pulses=%0d expected 0/1", restarted, done_cnt - d0);
        end
        checks++;
        if (wr_q.size() - w0 != 8 || err_code !== 2'd0 || words_loaded !== CNT_W'(8)) begin
            failures++;
            $display("FAIL ignored_start_status got writes=%0d err=%0d words=%0d expected 8/0/8",
                     wr_q.size() - w0, err_code, words_loaded);
        end else begin
            checks++;
            if (wr_q[w0+7].addr !== BASE_ADDR + 32'd7 || wr_q[w0+7].data !== 32'hC7) begin
                failures++;
                $display("FAIL ignored_start_last_write got addr=%0d data=%0h expected addr=23 data=c7",
                         wr_q[w0+7].addr, wr_q[w0+7].data);
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_ce_we_tied();
        checks++;
        if (ce_mismatch != 0) begin
            failures++;
            $display("FAIL ce_we_equal got %0d differing cycles expected 0", ce_mismatch);
        end
    endtask

    initial begin
        test_reset();
        test_nominal(0, "nominal");
        test_nominal(5, "throttled");
        test_underrun();
        test_overrun();
        test_reset_mid_load();
        test_ignored_start();
        test_ce_we_tied();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
